// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers.
// Independent write (W_IDLE/W_WRITE/W_RESP) and read (R_IDLE/R_DATA) state machines; all outputs registered.
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          AIDX_W = ADDR_WIDTH - 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}          rstate_t;

  logic [31:0]       r_regs [NUM_REGS];
  wstate_t           r_wstate, w_wstate_nxt;
  rstate_t           r_rstate, w_rstate_nxt;
  logic              r_aw_held, r_w_held;
  logic [AIDX_W-1:0] r_aw_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [31:0]       r_rdata;

  logic              w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
  logic [1:0]        w_bresp_nxt, w_rresp_nxt;
  logic [31:0]       w_rdata_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_held_nxt, w_w_held_nxt, w_aw_in_range, w_ar_in_range;
  logic [AIDX_W-1:0] w_ar_idx;
  logic w_unused_addr_bits;

  assign w_aw_hs       = AWVALID & r_awready;
  assign w_w_hs        = WVALID & r_wready;
  assign w_b_hs        = r_bvalid & BREADY;
  assign w_ar_hs       = ARVALID & r_arready;
  assign w_r_hs        = r_rvalid & RREADY;
  assign w_aw_held_nxt = r_aw_held | w_aw_hs;
  assign w_w_held_nxt  = r_w_held | w_w_hs;
  assign w_ar_idx      = ARADDR[ADDR_WIDTH-1:2];
  assign w_aw_in_range = (r_aw_idx < AIDX_W'(NUM_REGS));
  assign w_ar_in_range = (w_ar_idx < AIDX_W'(NUM_REGS));
  assign w_unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  // ---------------- write path ----------------
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
      if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_held_nxt && w_w_held_nxt) w_wstate_nxt = W_WRITE;
      W_WRITE: w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Next values of the registered write-channel outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    case (r_wstate)
      W_IDLE: begin
        w_awready_nxt = ~w_aw_held_nxt;
        w_wready_nxt  = ~w_w_held_nxt;
      end
      W_WRITE: begin
        w_bvalid_nxt = 1'b1;
        w_bresp_nxt  = w_aw_in_range ? OKAY : SLVERR;
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the register bank is reset explicitly, so it cannot map onto a reset-less RAM macro.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_wstate == W_WRITE && w_aw_in_range) begin
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) r_regs[r_aw_idx[IDX_W-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA: if (w_r_hs)  w_rstate_nxt = R_IDLE;
    endcase
  end

  // The bank is sampled before any same-edge write commit lands, so reads see the old value.
  always_comb begin
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = w_ar_in_range ? r_regs[w_ar_idx[IDX_W-1:0]] : 32'h0;
          w_rresp_nxt  = w_ar_in_range ? OKAY : SLVERR;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
        end
      end
    endcase
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: reset, full/partial writes, W-before-AW, out-of-range,
// backpressure and same-edge write/read ordering, with hand-computed expectations.
module tb_axi_lite_reg_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  int errors = 0;
  int checks = 0;

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int b_wait);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int n = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      tick();
      if (aw_now) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_now)  begin WVALID = 1'b0;  w_done = 1;  end
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
    if (aw_done && w_done) begin
      check("wr_bvalid_not_early", 32'(BVALID), 32'd0);
      tick();
      check("wr_bvalid_bresp", {27'd0, BVALID, BRESP, AWREADY, WREADY}, {27'd0, 1'b1, exp_resp, 2'b00});
      for (int i = 0; i < b_wait; i++) begin
        tick();
        check("wr_b_stall_stable", {27'd0, BVALID, BRESP, AWREADY, WREADY}, {27'd0, 1'b1, exp_resp, 2'b00});
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("wr_b_done_readies", {29'd0, BVALID, AWREADY, WREADY}, 32'b011);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_wait);
    bit hs = 0, hs_now;
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!hs && n < 20) begin
      hs_now = ARREADY;
      tick();
      if (hs_now) hs = 1;
      n++;
    end
    ARVALID = 1'b0;
    check("rd_handshake_done", 32'(hs), 32'd1);
    if (hs) begin
      check("rd_rvalid_rresp", {28'd0, RVALID, RRESP, ARREADY}, {28'd0, 1'b1, exp_resp, 1'b0});
      check("rd_rdata", RDATA, exp_data);
      for (int i = 0; i < r_wait; i++) begin
        tick();
        check("rd_r_stall_ctrl", {28'd0, RVALID, RRESP, ARREADY}, {28'd0, 1'b1, exp_resp, 1'b0});
        check("rd_r_stall_data", RDATA, exp_data);
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      check("rd_r_done", {30'd0, RVALID, ARREADY}, 32'b01);
    end
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset held for five edges: every output reads zero.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_ctrl", {24'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP[1]},
            32'd0);
      check("reset_rresp_rdata", {RRESP, RDATA[29:0]}, 32'd0);
    end
    ARESET = 1'b0;
    tick();
    check("post_reset_ready", {27'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID}, 32'b11100);

    axi_read(32'h00, 32'h0000_0000, 2'b00, 0);

    // Full-word writes and readback.
    axi_write(32'h00, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
    axi_read (32'h00, 32'hDEAD_BEEF, 2'b00, 0);
    axi_write(32'h04, 32'h1234_5678, 4'hF, 2'b00, 0);
    axi_read (32'h04, 32'h1234_5678, 2'b00, 0);
    axi_read (32'h00, 32'hDEAD_BEEF, 2'b00, 0);

    // Partial strobe: low two bytes only.
    axi_write(32'h00, 32'hAAAA_5555, 4'b0011, 2'b00, 0);
    axi_read (32'h00, 32'hDEAD_5555, 2'b00, 0);

    // Zero strobe in range changes nothing but answers OKAY; low address bits are ignored.
    axi_write(32'h04, 32'hFFFF_FFFF, 4'b0000, 2'b00, 0);
    axi_read (32'h07, 32'h1234_5678, 2'b00, 0);

    // W presented three cycles ahead of AW.
    AWADDR = 32'h08; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("wfirst_wready_low", {30'd0, WREADY, AWREADY}, 32'b01);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wfirst_no_bvalid", 32'(BVALID), 32'd0);
    end
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("wfirst_bvalid_after_aw", {30'd0, BVALID, AWREADY}, 32'b00);
    tick();
    check("wfirst_bvalid_bresp", {29'd0, BVALID, BRESP}, 32'b100);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("wfirst_b_done", {29'd0, BVALID, AWREADY, WREADY}, 32'b011);
    axi_read(32'h08, 32'hCAFE_F00D, 2'b00, 0);

    // Out-of-range index 16 (byte 0x40).
    axi_write(32'h40, 32'h5A5A_5A5A, 4'hF, 2'b10, 0);
    axi_read (32'h40, 32'h0000_0000, 2'b10, 0);
    axi_read (32'h3C, 32'h0000_0000, 2'b00, 0);
    axi_read (32'h00, 32'hDEAD_5555, 2'b00, 0);

    // Response backpressure on both channels.
    axi_write(32'h0C, 32'h1111_2222, 4'hF, 2'b00, 5);
    axi_read (32'h04, 32'h1234_5678, 2'b00, 5);

    // AR handshake on the same edge that commits a write to the same register.
    AWADDR = 32'h0C; WDATA = 32'h3333_4444; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h0C; ARVALID = 1'b1;
    check("same_edge_ar_ready", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    check("same_edge_valids", {30'd0, BVALID, RVALID}, 32'b11);
    check("same_edge_old_data", RDATA, 32'h1111_2222);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("same_edge_done", {28'd0, BVALID, RVALID, AWREADY, ARREADY}, 32'b0011);
    axi_read(32'h0C, 32'h3333_4444, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
